// File: rtl/cordicpol2cart.sv
// cordicpol2cart
//   Pipelined CORDIC rotation-mode converter, polar (theta, r) -> Cartesian (x, y).
//   Accepts the theta/r format produced by cordiccart2pol. One sample per clock,
//   latency ITERATIONS+3 cycles, no backpressure.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   in_valid   : theta/r carry a sample this cycle
//   theta      : unsigned angle, ITERATIONS+1 bits, full scale = one turn
//   r          : signed magnitude, DATA_WIDTH+2 bits
//   out_valid  : one-cycle strobe per accepted sample
//   xout, yout : signed r*cos(theta), r*sin(theta), saturated to DATA_WIDTH+2 bits
//
// Build option
//   CORDICPOL2CART_ROUND_EN : round the gain-compensation product half-up instead
//                             of truncating it. Latency and interface unchanged.
module cordicpol2cart #(
  parameter int ITERATIONS           = 7,
  parameter int DATA_WIDTH           = 16,
  parameter int COMPENSATION_SCALING = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [ITERATIONS:0]          theta,
  input  logic signed [DATA_WIDTH+1:0] r,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH+1:0] xout,
  output logic signed [DATA_WIDTH+1:0] yout
);

  // One guard bit above the input range absorbs the CORDIC gain (~1.647).
  localparam int XW = DATA_WIDTH + 3;
  // Angle word: sign, quadrant headroom, residual, three guard LSBs.
  localparam int ZW = ITERATIONS + 4;
  localparam int PW = XW + DATA_WIDTH + 1;

  // atan(2^-i) as a fraction of a full turn, scaled by 2^32 and rounded.
  // Beyond the table atan(x) ~= x is exact to well below one LSB.
  function automatic longint atan_frac32(input int i);
    case (i)
      0:       return 536870912;
      1:       return 316933406;
      2:       return 167458907;
      3:       return 85004756;
      4:       return 42667331;
      5:       return 21354465;
      6:       return 10679838;
      7:       return 5340245;
      8:       return 2670163;
      9:       return 1335087;
      10:      return 667544;
      11:      return 333772;
      12:      return 166886;
      13:      return 83443;
      14:      return 41722;
      15:      return 20861;
      default: return longint'(683565276) >> i;
    endcase
  endfunction

  // Round the 2^32 table entry down to the internal 2^ZW-per-turn angle unit.
  function automatic longint atan_scaled(input int i);
    return (atan_frac32(i) + (longint'(1) << (31 - ZW))) >> (32 - ZW);
  endfunction

  // KC = round(2^DATA_WIDTH / sqrt(prod(1 + 2^-2i))), found in integer arithmetic:
  // the product is formed in 2^-24 fixed point, then a bisection finds the largest
  // k with k^2 * P <= 2^(2*(DATA_WIDTH+1)), i.e. KC with one extra bit for rounding.
  function automatic longint calc_kc();
    longint p, lo, hi, mid, lim;
    p = longint'(1) << 24;
    for (int i = 0; i < ITERATIONS; i++) p = p + (p >>> (2 * i));
    lim = longint'(1) << (2 * (DATA_WIDTH + 1) + 24);
    lo  = 0;
    hi  = longint'(1) << (DATA_WIDTH + 1);
    for (int b = 0; b < DATA_WIDTH + 2; b++) begin
      mid = (lo + hi) >>> 1;
      if (mid * mid * p <= lim) lo = mid;
      else hi = mid;
    end
    return (lo + 1) >>> 1;
  endfunction

  localparam logic signed [DATA_WIDTH:0] KC_S = (DATA_WIDTH+1)'(calc_kc());

`ifdef CORDICPOL2CART_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(longint'(1) << (DATA_WIDTH - 1));
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  localparam logic signed [XW-1:0] SAT_MAX = XW'((longint'(1) << (DATA_WIDTH + 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(longint'(1) << (DATA_WIDTH + 1)));

  function automatic logic signed [DATA_WIDTH+1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH+1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH+1:0];
    else                  return v[DATA_WIDTH+1:0];
  endfunction

  logic signed [XW-1:0] x_p [ITERATIONS+1];
  logic signed [XW-1:0] y_p [ITERATIONS+1];
  logic signed [ZW-1:0] z_p [ITERATIONS];
  logic signed [XW-1:0] x_c, y_c;
  logic [ITERATIONS+1:0] v_p;

  // Stage 0 quadrant pre-rotation, then the micro-rotation stages.
  // The last stage needs no angle update, so z stops one stage early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ITERATIONS; i++) begin
        x_p[i] <= '0;
        y_p[i] <= '0;
      end
      for (int i = 0; i < ITERATIONS; i++) z_p[i] <= '0;
    end else begin
      case (theta[ITERATIONS:ITERATIONS-1])
        2'd0: begin x_p[0] <= XW'(r);   y_p[0] <= '0;       end
        2'd1: begin x_p[0] <= '0;       y_p[0] <= XW'(r);   end
        2'd2: begin x_p[0] <= -XW'(r);  y_p[0] <= '0;       end
        default: begin x_p[0] <= '0;    y_p[0] <= -XW'(r);  end
      endcase
      z_p[0] <= ZW'({theta[ITERATIONS-2:0], 3'b000});

      for (int i = 0; i < ITERATIONS; i++) begin
        if (!z_p[i][ZW-1]) begin
          x_p[i+1] <= x_p[i] - (y_p[i] >>> i);
          y_p[i+1] <= y_p[i] + (x_p[i] >>> i);
        end else begin
          x_p[i+1] <= x_p[i] + (y_p[i] >>> i);
          y_p[i+1] <= y_p[i] - (x_p[i] >>> i);
        end
      end
      for (int i = 0; i < ITERATIONS - 1; i++) begin
        if (!z_p[i][ZW-1]) z_p[i+1] <= z_p[i] - ZW'(atan_scaled(i));
        else               z_p[i+1] <= z_p[i] + ZW'(atan_scaled(i));
      end
    end
  end

  // Gain compensation. |x*KC| never exceeds |x|, so truncating back to XW is lossless.
  generate
    if (COMPENSATION_SCALING != 0) begin : g_comp
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_c <= '0;
          y_c <= '0;
        end else begin
          x_c <= XW'((PW'(x_p[ITERATIONS]) * PW'(KC_S) + RND) >>> DATA_WIDTH);
          y_c <= XW'((PW'(y_p[ITERATIONS]) * PW'(KC_S) + RND) >>> DATA_WIDTH);
        end
      end
    end else begin : g_nocomp
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_c <= '0;
          y_c <= '0;
        end else begin
          x_c <= x_p[ITERATIONS];
          y_c <= y_p[ITERATIONS];
        end
      end
    end
  endgenerate

  // v_p[k] qualifies the data registered on the same edge as the k-th data stage;
  // v_p[ITERATIONS+1] lines up with the compensation register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_p       <= '0;
      out_valid <= 1'b0;
      xout      <= '0;
      yout      <= '0;
    end else begin
      v_p       <= {v_p[ITERATIONS:0], in_valid};
      out_valid <= v_p[ITERATIONS+1];
      if (v_p[ITERATIONS+1]) begin
        xout <= sat(x_c);
        yout <= sat(y_c);
      end
    end
  end

endmodule

// File: tb/tb_cordicpol2cart.sv
module tb_cordicpol2cart;

  localparam int IT   = 7;
  localparam int DW   = 16;
  localparam int LAT  = IT + 3;
  localparam int NMAX = 256;
  localparam real PI  = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic [IT:0]          theta = '0;
  logic signed [DW+1:0] r = '0;
  logic                 out_valid, out_valid_nc;
  logic signed [DW+1:0] xout, yout, xout_nc, yout_nc;

  int checks = 0;
  int errors = 0;

  int     atan_t [IT];
  longint kc;

  // Expected held output values of both instances.
  int hold_x = 0, hold_y = 0, hold_xn = 0, hold_yn = 0;

  logic                 st_v  [NMAX];
  logic [IT:0]          st_th [NMAX];
  logic signed [DW+1:0] st_r  [NMAX];
  logic ob_v  [NMAX+LAT];
  logic ob_vn [NMAX+LAT];
  int   ob_x  [NMAX+LAT];
  int   ob_y  [NMAX+LAT];
  int   ob_xn [NMAX+LAT];
  int   ob_yn [NMAX+LAT];

  always #5 clk = ~clk;

  cordicpol2cart #(.ITERATIONS(IT), .DATA_WIDTH(DW), .COMPENSATION_SCALING(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .theta(theta), .r(r),
    .out_valid(out_valid), .xout(xout), .yout(yout)
  );

  cordicpol2cart #(.ITERATIONS(IT), .DATA_WIDTH(DW), .COMPENSATION_SCALING(0)) u_dut_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .theta(theta), .r(r),
    .out_valid(out_valid_nc), .xout(xout_nc), .yout(yout_nc)
  );

  // Reference: quadrant fold, rotation loop driven by real-valued arctangents,
  // optional gain correction, clamp.
  function automatic void model(input logic [IT:0] th, input logic signed [DW+1:0] rr,
                                input bit comp, output int xo, output int yo);
    longint x, y, z, xt, lim, rnd;
    case (th[IT:IT-1])
      2'd0:    begin x = longint'(rr);  y = 0;             end
      2'd1:    begin x = 0;             y = longint'(rr);  end
      2'd2:    begin x = -longint'(rr); y = 0;             end
      default: begin x = 0;             y = -longint'(rr); end
    endcase
    z = longint'(th[IT-2:0]) * 8;
    for (int i = 0; i < IT; i++) begin
      if (z >= 0) begin
        xt = x - (y >>> i); y = y + (x >>> i); x = xt; z = z - atan_t[i];
      end else begin
        xt = x + (y >>> i); y = y - (x >>> i); x = xt; z = z + atan_t[i];
      end
    end
`ifdef CORDICPOL2CART_ROUND_EN
    rnd = longint'(1) << (DW - 1);
`else
    rnd = 0;
`endif
    if (comp) begin
      x = (x * kc + rnd) >>> DW;
      y = (y * kc + rnd) >>> DW;
    end
    lim = longint'(1) << (DW + 1);
    if (x > lim - 1) x = lim - 1; else if (x < -lim) x = -lim;
    if (y > lim - 1) y = lim - 1; else if (y < -lim) y = -lim;
    xo = int'(x);
    yo = int'(y);
  endfunction

  // Plays st_* for n cycles then LAT idle cycles; records outputs half a cycle after each edge.
  task automatic drive_capture(input int n);
    for (int c = 0; c < n + LAT; c++) begin
      if (c < n) begin
        in_valid = st_v[c]; theta = st_th[c]; r = st_r[c];
      end else begin
        in_valid = 1'b0; theta = (IT+1)'($urandom); r = (DW+2)'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      ob_v[c]  = out_valid;    ob_x[c]  = int'(xout);    ob_y[c]  = int'(yout);
      ob_vn[c] = out_valid_nc; ob_xn[c] = int'(xout_nc); ob_yn[c] = int'(yout_nc);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom); theta = (IT+1)'($urandom); r = (DW+2)'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || xout !== '0 || yout !== '0) begin
        errors++;
        $display("FAIL reset_hold c=%0d: got v=%0b x=%0d y=%0d, want 0 0 0", c, out_valid, xout, yout);
      end
    end
    rst = 1'b0;
    hold_x = 0; hold_y = 0; hold_xn = 0; hold_yn = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b0; theta = (IT+1)'($urandom); r = (DW+2)'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || xout !== '0 || yout !== '0) begin
        errors++;
        $display("FAIL reset_release c=%0d: got v=%0b x=%0d y=%0d, want 0 0 0", c, out_valid, xout, yout);
      end
    end
  endtask

  task automatic test_quadrants();
    int ex, ey, dx, dy;
    bit ev;
    for (int q = 0; q < 4; q++) begin
      st_v[0] = 1'b1; st_th[0] = (IT+1)'(q * 64); st_r[0] = 10000;
      drive_capture(1);
      for (int c = 0; c < LAT + 1; c++) begin
        ev = (c == LAT - 1);
        checks++;
        if (ob_v[c] !== ev) begin
          errors++;
          $display("FAIL quad%0d_valid c=%0d: got %0b, want %0b", q, c, ob_v[c], ev);
        end
      end
      model(st_th[0], st_r[0], 1'b1, hold_x, hold_y);
      model(st_th[0], st_r[0], 1'b0, hold_xn, hold_yn);
      checks++;
      if (ob_x[LAT-1] !== hold_x || ob_y[LAT-1] !== hold_y) begin
        errors++;
        $display("FAIL quad%0d_exact: got (%0d,%0d), want (%0d,%0d)", q, ob_x[LAT-1], ob_y[LAT-1], hold_x, hold_y);
      end
      ex = $rtoi($floor(10000.0 * $cos(q * PI / 2.0) + 0.5));
      ey = $rtoi($floor(10000.0 * $sin(q * PI / 2.0) + 0.5));
      dx = ob_x[LAT-1] - ex; dy = ob_y[LAT-1] - ey;
      checks++;
      if (dx > 200 || dx < -200 || dy > 200 || dy < -200) begin
        errors++;
        $display("FAIL quad%0d_ideal: got (%0d,%0d), want (%0d,%0d) +-200", q, ob_x[LAT-1], ob_y[LAT-1], ex, ey);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, k;
    bit ev;
    n = 200;
    for (int i = 0; i < n; i++) begin
      st_v[i] = 1'b1; st_th[i] = (IT+1)'($urandom); st_r[i] = (DW+2)'($urandom);
    end
    st_th[0] = '1; st_r[0] = -(DW+2)'(131072);
    st_th[1] = 8'h80; st_r[1] = -(DW+2)'(131072);
    drive_capture(n);
    for (int c = 0; c < n + LAT; c++) begin
      k = c - (LAT - 1);
      ev = (k >= 0 && k < n) ? st_v[k] : 1'b0;
      if (ev) model(st_th[k], st_r[k], 1'b1, hold_x, hold_y);
      checks++;
      if (ob_v[c] !== ev || ob_x[c] !== hold_x || ob_y[c] !== hold_y) begin
        errors++;
        $display("FAIL b2b c=%0d: got v=%0b (%0d,%0d), want v=%0b (%0d,%0d)",
                 c, ob_v[c], ob_x[c], ob_y[c], ev, hold_x, hold_y);
      end
      if (ev) model(st_th[k], st_r[k], 1'b0, hold_xn, hold_yn);
    end
  endtask

  task automatic test_random_valid();
    int n, k;
    bit ev;
    n = 200;
    for (int i = 0; i < n; i++) begin
      st_v[i] = 1'($urandom); st_th[i] = (IT+1)'($urandom); st_r[i] = (DW+2)'($urandom);
    end
    drive_capture(n);
    for (int c = 0; c < n + LAT; c++) begin
      k = c - (LAT - 1);
      ev = (k >= 0 && k < n) ? st_v[k] : 1'b0;
      if (ev) begin
        model(st_th[k], st_r[k], 1'b1, hold_x, hold_y);
        model(st_th[k], st_r[k], 1'b0, hold_xn, hold_yn);
      end
      checks++;
      if (ob_v[c] !== ev || ob_x[c] !== hold_x || ob_y[c] !== hold_y) begin
        errors++;
        $display("FAIL rand_comp c=%0d: got v=%0b (%0d,%0d), want v=%0b (%0d,%0d)",
                 c, ob_v[c], ob_x[c], ob_y[c], ev, hold_x, hold_y);
      end
      checks++;
      if (ob_vn[c] !== ev || ob_xn[c] !== hold_xn || ob_yn[c] !== hold_yn) begin
        errors++;
        $display("FAIL rand_nocomp c=%0d: got v=%0b (%0d,%0d), want v=%0b (%0d,%0d)",
                 c, ob_vn[c], ob_xn[c], ob_yn[c], ev, hold_xn, hold_yn);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [6:0] pat;
    int n, k;
    bit ev;
    pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    n = 7;
    for (int i = 0; i < n; i++) begin
      st_v[i] = pat[i]; st_th[i] = (IT+1)'($urandom); st_r[i] = (DW+2)'($urandom);
    end
    drive_capture(n);
    for (int c = 0; c < n + LAT; c++) begin
      k = c - (LAT - 1);
      ev = (k >= 0 && k < n) ? st_v[k] : 1'b0;
      if (ev) model(st_th[k], st_r[k], 1'b1, hold_x, hold_y);
      checks++;
      if (ob_v[c] !== ev || ob_x[c] !== hold_x || ob_y[c] !== hold_y) begin
        errors++;
        $display("FAIL bubbles c=%0d: got v=%0b (%0d,%0d), want v=%0b (%0d,%0d)",
                 c, ob_v[c], ob_x[c], ob_y[c], ev, hold_x, hold_y);
      end
      if (ev) model(st_th[k], st_r[k], 1'b0, hold_xn, hold_yn);
    end
  endtask

  task automatic test_reset_midstream();
    bit ev;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; theta = (IT+1)'($urandom); r = (DW+2)'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || xout !== '0 || yout !== '0) begin
      errors++;
      $display("FAIL midrst_async: got v=%0b x=%0d y=%0d, want 0 0 0", out_valid, xout, yout);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold_x = 0; hold_y = 0; hold_xn = 0; hold_yn = 0;
    st_v[0] = 1'b1; st_th[0] = (IT+1)'($urandom); st_r[0] = (DW+2)'($urandom);
    drive_capture(1);
    model(st_th[0], st_r[0], 1'b1, hold_x, hold_y);
    model(st_th[0], st_r[0], 1'b0, hold_xn, hold_yn);
    for (int c = 0; c < LAT + 1; c++) begin
      ev = (c == LAT - 1);
      checks++;
      if (ob_v[c] !== ev) begin
        errors++;
        $display("FAIL midrst_valid c=%0d: got %0b, want %0b", c, ob_v[c], ev);
      end
    end
    checks++;
    if (ob_x[LAT-1] !== hold_x || ob_y[LAT-1] !== hold_y) begin
      errors++;
      $display("FAIL midrst_data: got (%0d,%0d), want (%0d,%0d)", ob_x[LAT-1], ob_y[LAT-1], hold_x, hold_y);
    end
  endtask

  task automatic test_saturation();
    st_v[0] = 1'b1; st_th[0] = '0; st_r[0] = 131071;
    drive_capture(1);
    model(st_th[0], st_r[0], 1'b1, hold_x, hold_y);
    model(st_th[0], st_r[0], 1'b0, hold_xn, hold_yn);
    checks++;
    if (ob_vn[LAT-1] !== 1'b1 || ob_xn[LAT-1] !== 131071) begin
      errors++;
      $display("FAIL sat_x: got v=%0b x=%0d, want v=1 x=131071", ob_vn[LAT-1], ob_xn[LAT-1]);
    end
    checks++;
    if (ob_yn[LAT-1] > 3000 || ob_yn[LAT-1] < -3000 || ob_yn[LAT-1] !== hold_yn) begin
      errors++;
      $display("FAIL sat_y: got %0d, want %0d (within +-3000 of 0)", ob_yn[LAT-1], hold_yn);
    end
    checks++;
    if (ob_x[LAT-1] !== hold_x || ob_y[LAT-1] !== hold_y) begin
      errors++;
      $display("FAIL sat_comp: got (%0d,%0d), want (%0d,%0d)", ob_x[LAT-1], ob_y[LAT-1], hold_x, hold_y);
    end
  endtask

  initial begin
    real k;
    for (int i = 0; i < IT; i++)
      atan_t[i] = $rtoi($floor($atan(2.0 ** (-i)) * (2.0 ** (IT + 4)) / (2.0 * PI) + 0.5));
    k = 1.0;
    for (int i = 0; i < IT; i++) k = k / $sqrt(1.0 + 2.0 ** (-2 * i));
    kc = longint'($rtoi($floor(k * (2.0 ** DW) + 0.5)));

    #1;
    test_reset();
    test_quadrants();
    test_back_to_back();
    test_random_valid();
    test_bubbles();
    test_reset_midstream();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordicpol2cart.md
# cordicpol2cart

Pipelined CORDIC rotation-mode converter from polar (angle, magnitude) to Cartesian (x, y). Sits directly downstream of `cordiccart2pol`. It accepts that block's `theta`/`r` output format unchanged, so the pair forms a round-trip chain for amplitude/phase processing. Data is streamed one sample per clock, and a valid bit is carried alongside each sample.

## Interface
- `ITERATIONS`, 7: number of CORDIC micro-rotations; the angle input width is `ITERATIONS+1`.
- `DATA_WIDTH`, 16: base sample width; magnitude and outputs are `DATA_WIDTH+2` bits.
- `COMPENSATION_SCALING`, 1: 1 multiplies outputs by the CORDIC gain inverse; 0 leaves the gain uncorrected.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `in_valid` in 1: marks `theta`/`r` as a sample.
- `theta` in `ITERATIONS+1`: unsigned angle; 1 LSB = 2π/2^(ITERATIONS+1); 0x00 = 0°, 0x40 = 90° at default.
- `r` in `DATA_WIDTH+2`: signed magnitude.
- `out_valid` out 1: marks `xout`/`yout` as a new result.
- `xout` out `DATA_WIDTH+2`: signed r·cos(theta).
- `yout` out `DATA_WIDTH+2`: signed r·sin(theta).

## Operation
- **Stage 0 (quadrant pre-rotation).** `q = theta[ITERATIONS:ITERATIONS-1]`.
  - q=0: (x,y) = (r,0).
  - q=1: (x,y) = (0,r).
  - q=2: (x,y) = (−r,0).
  - q=3: (x,y) = (0,−r).
  - Residual `z = theta[ITERATIONS-2:0]` is zero-extended and scaled into the internal angle word, so z lies in [0°, 90°).
- **Internal widths.**
  - x/y: signed `DATA_WIDTH+3`. This holds gain growth for the largest |r| without wrap.
  - z: signed `ITERATIONS+4`, giving 3 guard LSBs below the input angle LSB.
- **Angle table.** `atan_i = round(atan(2^-i)·2^(ITERATIONS+4)/(2π))`, computed at elaboration for i = 0..ITERATIONS−1.
- **Stages 1..ITERATIONS (micro-rotations).**
  - d = +1 if z ≥ 0, else −1.
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
  - Shifts are arithmetic; no rounding inside the iterations.
- **Compensation stage.**
  - With `COMPENSATION_SCALING=1`: x·KC and y·KC, then arithmetic shift right by `DATA_WIDTH`, where KC = round(2^DATA_WIDTH·∏(1/√(1+2^-2i))).
  - With `COMPENSATION_SCALING=0`: a plain register, so latency is unchanged.
- **Output stage.**
  - Saturate to the `DATA_WIDTH+2` signed range: [−2^(DATA_WIDTH+1), 2^(DATA_WIDTH+1)−1].
  - `xout`/`yout` load only when the valid bit leaving the pipe is 1; otherwise they hold their last value.
- **Negative `r`.** Not rejected; the result is the point at theta+180°, with the same arithmetic.
- **Valid path.** A shift register of depth equal to the latency, carried in lockstep with the data; bubbles are preserved exactly.

## Timing
- Latency is `ITERATIONS+3` cycles from a sampling edge with `in_valid=1` to the edge that raises `out_valid`. This is 10 at the default parameters.
- Throughput is one sample per clock; there is no backpressure and no stall input.
- `out_valid` is high for exactly one cycle per accepted sample. Back-to-back inputs give back-to-back outputs.
- Reset values: `out_valid`=0, `xout`=0, `yout`=0, and all valid-pipe bits and data-pipe registers are 0.
- Reset asserted mid-stream discards every in-flight sample. After release, `out_valid` stays 0 until a new sample has traversed the full latency.
- `in_valid=0` inputs propagate through the data pipe but never reach the outputs.

## Configuration
- `CORDICPOL2CART_ROUND_EN` defined:
  - The compensation product adds 2^(DATA_WIDTH−1) before the shift (round half up).
  - With `COMPENSATION_SCALING=0`, the final iteration outputs are passed unchanged.
- Macro not defined: the compensation product is truncated (floor via arithmetic shift).
- Latency and interface are identical in both builds.

## Test plan
All scenarios use the default parameters unless stated.
- **Reset.** Hold `rst` for 100 ns with random inputs toggling -> `xout`=`yout`=0 and `out_valid`=0 throughout reset and for 10 cycles after release.
- **Golden-file stream.** 1000 back-to-back samples read from `test_cordic_pol2cart_input_{theta,r}.txt` -> `out_valid` first rises on the 10th edge; `xout`/`yout` are bit-exact to `test_cordic_pol2cart_output_{x,y}.txt` for both macro builds, using separate golden sets.
- **Quadrant points.** `theta` = 0x00, 0x40, 0x80, 0xC0 with `r`=10000 -> outputs are (≈10000, ≈0), (≈0, ≈10000), (≈−10000, ≈0), (≈0, ≈−10000), each coordinate within ±200 of ideal.
- **Bubbles.** `in_valid` pattern 1,0,0,1,1,0,1 -> identical `out_valid` pattern delayed 10 cycles; `xout`/`yout` hold their value during the 0 cycles.
- **Reset mid-stream.** Pulse `rst` for 2 cycles while 5 samples are in flight -> none of those samples ever produce `out_valid`; the next sample appears exactly 10 cycles after it is applied.
- **Saturation.** With `COMPENSATION_SCALING=0`, `r`=131071 and `theta`=0x00 -> `xout`=131071 (saturated) and `yout` within ±3000 of 0.
